// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and frame constants.
package uart_tx_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick in the last cycle of each bit.
module uart_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter (8N1) with a one-byte holding register for back-to-back frames.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    state_t               state_q, state_d;
    logic                 tick;
    logic                 baud_clear;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 tx_q, tx_d;
    logic                 ready_q;
    logic                 load;
    logic                 accept;

    // Held at zero while idle so the first START cycle begins a full bit period.
    assign baud_clear = (state_q == IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(baud_clear),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (hold_full_q) state_d = START;
            START: if (tick) state_d = DATA;
            DATA:  if (tick && bit_idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
            STOP:  if (tick) state_d = hold_full_q ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // tx is registered from the next state so the line changes on the transition edge.
    always_comb begin
        load        = (state_d == START) && (state_q != START);
        accept      = tx_valid && ready_q;
        hold_d      = accept ? tx_data : hold_q;
        hold_full_d = load ? 1'b0 : (accept ? 1'b1 : hold_full_q);
        if (load) begin
            shift_d = hold_q;
        end else if (state_q == DATA && tick) begin
            shift_d = shift_q >> 1;
        end else begin
            shift_d = shift_q;
        end
        bit_idx_d = (state_q == DATA && tick) ? bit_idx_q + 3'd1 : bit_idx_q;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy = (state_q != IDLE) || hold_full_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            tx_q        <= 1'b1;
            ready_q     <= 1'b1;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            tx_q        <= tx_d;
            ready_q     <= !hold_full_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;

endmodule
